// File: rtl/image_pkg.sv
// ============================================================================
// image_pkg : shared pixel, tile and window types for the image tile buffer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package image_pkg;

  localparam int PIXEL_BITS = 4;
  localparam int TILE_DIM   = 4;
  localparam int WIN_DIM    = 3;

  typedef logic [PIXEL_BITS-1:0] pixel_t;
  typedef pixel_t [TILE_DIM-1:0][TILE_DIM-1:0] tile_t;
  typedef pixel_t [WIN_DIM-1:0][WIN_DIM-1:0]   window_t;

  localparam logic [1:0] POS_TL = 2'd0;
  localparam logic [1:0] POS_TR = 2'd1;
  localparam logic [1:0] POS_BL = 2'd2;
  localparam logic [1:0] POS_BR = 2'd3;

  // Raster order over a 2x2 grid of placements: bit 1 is the row, bit 0 the column.
  function automatic logic [1:0] pos_row_off(input logic [1:0] pos);
    return {1'b0, pos[1]};
  endfunction

  function automatic logic [1:0] pos_col_off(input logic [1:0] pos);
    return {1'b0, pos[0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/window_select.sv
// ============================================================================
// window_select : combinational 3x3 window mux over the stored 4x4 tile
// Revision      : 1.0
// ============================================================================
`default_nettype none

module window_select
  import image_pkg::*;
(
  input  tile_t      tile,
  input  logic [1:0] pos,
  output window_t    window
);

  logic [1:0] row_off;
  logic [1:0] col_off;

  assign row_off = pos_row_off(pos);
  assign col_off = pos_col_off(pos);

  for (genvar r = 0; r < WIN_DIM; r++) begin : g_row
    for (genvar c = 0; c < WIN_DIM; c++) begin : g_col
      assign window[r][c] = tile[2'(r) + row_off][2'(c) + col_off];
    end
  end

endmodule

`default_nettype wire

// File: rtl/image_buffer.sv
// ============================================================================
// image_buffer : 4x4 pixel tile store presenting a sliding 3x3 window
// Revision     : 1.0
// ============================================================================
`default_nettype none

module image_buffer
  import image_pkg::*;
(
  input  logic    clk,
  input  logic    n_rst,
  input  logic    load_enable,
  input  logic    calc_done,
  input  tile_t   input_pixels,
  output window_t output_pixels
);

  tile_t      tile;
  logic [1:0] pos;

  // A load restarts the walk at the top-left placement and overrides calc_done.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tile <= '0;
      pos  <= POS_TL;
    end else if (load_enable) begin
      tile <= input_pixels;
      pos  <= POS_TL;
    end else if (calc_done) begin
      pos  <= pos + 2'd1;
    end
  end

  window_select u_window_select (
    .tile   (tile),
    .pos    (pos),
    .window (output_pixels)
  );

endmodule

`default_nettype wire

// File: tb/tb_image_buffer.sv
// ============================================================================
// tb_image_buffer : directed stimulus with a queued-expectation scoreboard
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_image_buffer;
  import image_pkg::*;

  logic    clk;
  logic    n_rst;
  logic    load_enable;
  logic    calc_done;
  tile_t   input_pixels;
  window_t output_pixels;

  image_buffer dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .load_enable   (load_enable),
    .calc_done     (calc_done),
    .input_pixels  (input_pixels),
    .output_pixels (output_pixels)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  window_t exp_q[$];
  string   name_q[$];
  event    sample_ev;
  int      passed = 0;
  int      total  = 0;

  tile_t tile_a;
  tile_t tile_b;
  tile_t zero_tile;

  // Reference: window whose top-left corner sits at (ro, co) of the tile.
  function automatic window_t win(input tile_t t, input int ro, input int co);
    window_t w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[r][c] = t[r + ro][c + co];
    return w;
  endfunction

  task automatic expect_win(input string name, input window_t w);
    exp_q.push_back(w);
    name_q.push_back(name);
    -> sample_ev;
  endtask

  // Drive inputs away from the edge, then land 1 ns after the capturing edge.
  task automatic cycle(input logic ld, input logic cd, input tile_t px);
    @(negedge clk);
    load_enable  = ld;
    calc_done    = cd;
    input_pixels = px;
    @(posedge clk);
    #1;
  endtask

  // Monitor: drains the scoreboard whenever the stimulus signals a sample point.
  initial begin
    window_t e;
    string   n;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        total++;
        if (output_pixels === e) passed++;
        else $display("FAIL %s: got %h expected %h", n, output_pixels, e);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    zero_tile = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        tile_a[r][c] = 4'(r * 4 + c);
        tile_b[r][c] = 4'(15 - (r * 4 + c));
      end

    n_rst        = 1'b1;
    load_enable  = 1'b0;
    calc_done    = 1'b0;
    input_pixels = tile_b;
    #2 n_rst = 1'b0;

    // Reset held for two cycles, then released with a nonzero idle input.
    @(posedge clk);
    @(posedge clk);
    #1 expect_win("reset_asserted", '0);
    @(negedge clk);
    n_rst = 1'b1;
    cycle(1'b0, 1'b0, tile_b);
    expect_win("reset_release_idle", '0);
    cycle(1'b0, 1'b0, tile_b);
    expect_win("reset_idle_nonzero_in", '0);

    // Load held two cycles.
    cycle(1'b1, 1'b0, tile_a);
    expect_win("load_cycle1", win(tile_a, 0, 0));
    cycle(1'b1, 1'b0, tile_a);
    expect_win("load_cycle2", win(tile_a, 0, 0));

    // Walk through all four placements and wrap.
    cycle(1'b0, 1'b1, tile_b);
    expect_win("advance_tr", win(tile_a, 0, 1));
    cycle(1'b0, 1'b0, tile_b);
    cycle(1'b0, 1'b1, tile_b);
    expect_win("advance_bl", win(tile_a, 1, 0));
    cycle(1'b0, 1'b0, tile_b);
    cycle(1'b0, 1'b1, tile_b);
    expect_win("advance_br", win(tile_a, 1, 1));
    cycle(1'b0, 1'b0, tile_b);
    cycle(1'b0, 1'b1, tile_b);
    expect_win("advance_wrap_tl", win(tile_a, 0, 0));

    // Move to pos 2, then load and calc_done together.
    cycle(1'b0, 1'b1, tile_b);
    cycle(1'b0, 1'b1, tile_b);
    expect_win("pre_priority_bl", win(tile_a, 1, 0));
    cycle(1'b1, 1'b1, tile_b);
    expect_win("priority_load", win(tile_b, 0, 0));
    cycle(1'b0, 1'b1, tile_a);
    expect_win("priority_then_adv", win(tile_b, 0, 1));

    // Hold with wandering input pixels.
    for (int i = 0; i < 10; i++) begin
      tile_t rnd;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          rnd[r][c] = 4'($urandom_range(15, 0));
      cycle(1'b0, 1'b0, rnd);
      expect_win($sformatf("hold_%0d", i), win(tile_b, 0, 1));
    end

    // calc_done held two cycles advances twice.
    cycle(1'b0, 1'b1, tile_a);
    expect_win("held_calc_1", win(tile_b, 1, 0));
    cycle(1'b0, 1'b1, tile_a);
    expect_win("held_calc_2", win(tile_b, 1, 1));

    // Asynchronous reset between edges while at pos 3.
    @(negedge clk);
    load_enable = 1'b0;
    calc_done   = 1'b0;
    #2 n_rst = 1'b0;
    #1 expect_win("async_reset_midcycle", '0);
    @(negedge clk);
    n_rst = 1'b1;
    cycle(1'b0, 1'b1, tile_a);
    expect_win("post_reset_advance_zero", '0);
    cycle(1'b0, 1'b0, tile_a);

    // After reset and one advance, a fresh load starts again at the top-left.
    cycle(1'b1, 1'b0, tile_a);
    expect_win("reload_after_reset", win(tile_a, 0, 0));
    cycle(1'b0, 1'b1, tile_b);
    expect_win("reload_advance_tr", win(tile_a, 0, 1));

    #20;
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
